// File: rtl/counter_module_if.sv
// Handshake bundle for counter_module: control inputs from the producer, count and status back to it.
// The master modport is the side that drives the controls; the counter itself uses the slave modport.
interface counter_module_if #(
  parameter int WIDTH = 32
) ();
  logic             enable;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] counter;
  logic             max_flag;
  logic             wrap;

  modport master (
    output enable,
    output clear,
    output load,
    output load_value,
    input  counter,
    input  max_flag,
    input  wrap
  );

  modport slave (
    input  enable,
    input  clear,
    input  load,
    input  load_value,
    output counter,
    output max_flag,
    output wrap
  );
endinterface

// File: rtl/counter_module.sv
// Run-length event counter with clear > load > enable priority and a one-cycle wrap pulse.
// Define COUNTER_MODULE_SATURATE_EN to hold at all-ones on overflow instead of wrapping to zero.
module counter_module #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            reset,
  counter_module_if.slave bus
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_INC   = 2'd1,
    OP_LOAD  = 2'd2,
    OP_CLEAR = 2'd3
  } op_e;

  op_e              op_s;
  logic [WIDTH-1:0] counter_d;
  logic [WIDTH-1:0] counter_q;
  logic             wrap_d;
  logic             wrap_q;
  logic             max_flag_d;
  logic             max_flag_q;

  function automatic logic is_all_ones(input logic [WIDTH-1:0] value);
    return (value == ALL_ONES);
  endfunction

  // Resolve the per-edge operation by priority.
  always_comb begin
    op_s = OP_HOLD;
    if (bus.clear) begin
      op_s = OP_CLEAR;
    end else if (bus.load) begin
      op_s = OP_LOAD;
    end else if (bus.enable) begin
      op_s = OP_INC;
    end else begin
      op_s = OP_HOLD;
    end
  end

  // Next count, overflow pulse and all-ones flag for the selected operation.
  always_comb begin
    counter_d = counter_q;
    wrap_d    = 1'b0;
    case (op_s)
      OP_CLEAR: counter_d = '0;
      OP_LOAD:  counter_d = bus.load_value;
      OP_INC: begin
        wrap_d = is_all_ones(counter_q);
`ifdef COUNTER_MODULE_SATURATE_EN
        if (is_all_ones(counter_q)) begin
          counter_d = counter_q;
        end else begin
          counter_d = counter_q + ONE;
        end
`else
        counter_d = counter_q + ONE;
`endif
      end
      OP_HOLD:  counter_d = counter_q;
      default:  counter_d = counter_q;
    endcase
    // Flag is decoded from the next value so it lines up with the registered count.
    max_flag_d = is_all_ones(counter_d);
  end

  // State registers; reset clears everything without waiting for a clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter_q  <= '0;
      wrap_q     <= 1'b0;
      max_flag_q <= 1'b0;
    end else begin
      counter_q  <= counter_d;
      wrap_q     <= wrap_d;
      max_flag_q <= max_flag_d;
    end
  end

  assign bus.counter  = counter_q;
  assign bus.wrap     = wrap_q;
  assign bus.max_flag = max_flag_q;

endmodule

// File: tb/tb_counter_module.sv
// Randomized self-checking bench for counter_module against an arithmetic reference count.
module tb_counter_module;

  localparam int W = 32;
  localparam logic [63:0] MOD    = 64'd1 << W;
  localparam logic [63:0] MAXVAL = MOD - 64'd1;

  logic clk;
  logic reset;
  int   chk_cnt;
  int   pass_cnt;

  logic [63:0] model_cnt;
  logic        model_wrap;

  counter_module_if #(.WIDTH(W)) bus ();

  counter_module #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    chk_cnt++;
    if (observed === expected) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".counter"}, {32'd0, bus.counter}, model_cnt);
    check({tag, ".wrap"}, {63'd0, bus.wrap}, {63'd0, model_wrap});
    check({tag, ".max_flag"}, {63'd0, bus.max_flag}, {63'd0, (model_cnt == MAXVAL)});
  endtask

  // One clock edge: drive inputs, advance the reference count, sample 1 time unit after the edge.
  task automatic step(input logic en, input logic clr, input logic ld, input logic [W-1:0] lv,
                      input string tag);
    bus.enable     = en;
    bus.clear      = clr;
    bus.load       = ld;
    bus.load_value = lv;
    @(posedge clk);
    model_wrap = 1'b0;
    if (clr) begin
      model_cnt = 64'd0;
    end else if (ld) begin
      model_cnt = {32'd0, lv};
    end else if (en) begin
      model_wrap = (model_cnt == MAXVAL);
`ifdef COUNTER_MODULE_SATURATE_EN
      if (model_cnt != MAXVAL) model_cnt = model_cnt + 64'd1;
`else
      model_cnt = (model_cnt + 64'd1) % MOD;
`endif
    end
    #1;
    check_outputs(tag);
  endtask

  initial begin
    chk_cnt        = 0;
    pass_cnt       = 0;
    model_cnt      = 64'd0;
    model_wrap     = 1'b0;
    reset          = 1'b0;
    bus.enable     = 1'b0;
    bus.clear      = 1'b0;
    bus.load       = 1'b0;
    bus.load_value = '0;

    // Reset state, then release between edges.
    repeat (2) @(posedge clk);
    #3;
    check_outputs("reset");
    reset = 1'b1;

    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0, "count");
      check("count_val", {32'd0, bus.counter}, i);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0, "hold");
    check("hold_10", {32'd0, bus.counter}, 64'd10);

    // Priority: clear beats load and enable, then load alone.
    step(1'b0, 1'b0, 1'b1, 32'd7, "load7");
    step(1'b1, 1'b1, 1'b1, 32'h1234, "prio_all");
    check("prio_zero", {32'd0, bus.counter}, 64'd0);
    step(1'b0, 1'b0, 1'b1, 32'h1234, "prio_load");
    check("prio_1234", {32'd0, bus.counter}, 64'h1234);

    // Wrap / saturate boundary around all-ones.
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, "wrap_load");
    step(1'b1, 1'b0, 1'b0, 32'h0, "wrap_inc1");
    check("wrap_max", {63'd0, bus.max_flag}, 64'd1);
    step(1'b1, 1'b0, 1'b0, 32'h0, "wrap_inc2");
    check("wrap_pulse", {63'd0, bus.wrap}, 64'd1);
    step(1'b0, 1'b0, 1'b0, 32'h0, "wrap_drop");
    check("wrap_once", {63'd0, bus.wrap}, 64'd0);
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, "sat_load");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0, "sat_inc");
    // Load of zero right after overflow must not pulse wrap.
    step(1'b1, 1'b0, 1'b1, 32'h0, "load_nowrap");

    // Run-length use: clear on each new name with enable held high.
    begin
      int runs [3] = '{3, 1, 4};
      for (int r = 0; r < 3; r++) begin
        step(1'b1, 1'b1, 1'b0, 32'h0, "run_clear");
        for (int k = 1; k < runs[r]; k++) step(1'b1, 1'b0, 1'b0, 32'h0, "run_inc");
        check("run_len", {32'd0, bus.counter}, runs[r] - 1);
      end
    end

    // Asynchronous reset mid-cycle while counter is 5.
    step(1'b0, 1'b0, 1'b1, 32'd5, "pre_reset");
    #2;
    reset = 1'b0;
    model_cnt  = 64'd0;
    model_wrap = 1'b0;
    #1;
    check_outputs("async_reset");
    @(negedge clk);
    reset = 1'b1;

    // Randomized traffic with biased loads near all-ones.
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] lv;
      int sel;
      sel = $urandom_range(0, 3);
      case (sel)
        0:       lv = 32'hFFFF_FFFF - $urandom_range(0, 3);
        1:       lv = $urandom_range(0, 15);
        default: lv = $urandom;
      endcase
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 9) == 0), lv, "rand");
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/counter_module.md
# counter_module

Free-running 32-bit event counter with count enable, asynchronous active-low reset, synchronous clear and parallel load. It counts clock cycles on which `enable` is high and is used by the name-compression pipeline to measure run lengths of identical record names. The count is packed into the low 32 bits of the compressed output word. Registered output only; no combinational path from inputs to `counter`.

## Interface
- `WIDTH`, default 32: counter width in bits; must be ≥ 2.
- `clk` input 1: rising-edge clock; all state is updated on `posedge clk`.
- `reset` input 1: asynchronous, active-low reset. Low clears all state immediately, independent of `clk`.
- `enable` input 1: count enable; counter increments on each rising edge where it is high.
- `clear` input 1: synchronous clear to 0.
- `load` input 1: synchronous parallel load.
- `load_value` input WIDTH: value taken when `load` is high.
- `counter` output WIDTH: current count (register output).
- `max_flag` output 1: high while `counter` equals all-ones (combinational decode of the register).
- `wrap` output 1: registered one-cycle pulse, high for the cycle after an increment from all-ones.

## Operation
- Reset (`reset` = 0) forces `counter` = 0 and `wrap` = 0. `max_flag` = 0 follows from `counter` = 0. Outputs stay there while `reset` is low.
- Priority on each rising edge, with `reset` high: `clear` > `load` > `enable` > hold.
- `clear` = 1: `counter` ← 0 and `wrap` ← 0.
- `load` = 1 and `clear` = 0: `counter` ← `load_value` and `wrap` ← 0. `enable` is ignored that cycle.
- `enable` = 1 with no clear or load: `counter` ← `counter` + 1, modulo 2^WIDTH.
  - `wrap` ← 1 if the old value was all-ones, otherwise `wrap` ← 0.
- Otherwise `counter` holds and `wrap` ← 0.
- `max_flag` = (`counter` == {WIDTH{1'b1}}).
- Unsigned arithmetic only; no carry output beyond `wrap`.

## Timing
- Latency: one cycle. Inputs sampled at edge k appear on `counter` after edge k.
- `enable` held high for N edges from 0 gives `counter` = N after the Nth edge.
- Reset assertion is asynchronous. Reset deassertion is synchronized externally; the first edge with `reset` high may already count.
- Reset asserted mid-count clears immediately. Counting resumes from 0 after release; no previous value is retained.
- Simultaneous `clear` and `load` and `enable`: `clear` wins, so `counter` = 0 after the edge.
- `wrap` lasts exactly one cycle. It is not asserted by load or clear, even when the result is 0.

## Configuration
- `COUNTER_MODULE_SATURATE_EN` defined:
  - An increment from all-ones leaves `counter` at all-ones; it does not wrap.
  - `wrap` still pulses for one cycle on each attempted increment past all-ones, indicating overflow.
- Not defined: modulo-2^WIDTH wrap as specified in Operation.
- Clear, load and reset behaviour are identical in both builds.

## Test plan
- Reset: drive `reset` = 0 asynchronously mid-cycle while `counter` = 5 -> `counter` = 0 immediately with no clock edge; `wrap` = 0, `max_flag` = 0.
- Count: `enable` = 1 for 10 edges from 0, then `enable` = 0 for 3 edges -> `counter` reads 1..10, then holds at 10.
- Priority: `counter` = 7; on one edge drive `clear` = 1, `load` = 1 with `load_value` = 0x1234, and `enable` = 1 -> `counter` = 0. On the next edge drive `load` = 1 only -> `counter` = 0x1234.
- Wrap, macro undefined: load 0xFFFFFFFE, then `enable` for 2 edges -> `counter` = 0xFFFFFFFF with `max_flag` = 1, then 0x00000000 with `wrap` = 1 for exactly one cycle.
- Saturate, `COUNTER_MODULE_SATURATE_EN` defined: load 0xFFFFFFFF, then `enable` for 3 edges -> `counter` stays 0xFFFFFFFF, `wrap` high on each of those cycles, `max_flag` = 1 throughout.
- Run-length use: pulse `clear` each time a new name arrives, with `enable` = 1 constantly; name runs of lengths 3, 1 and 4 -> `counter` sequence restarts at 0 on each clear and reaches 2, 0 and 3 before the next clear.
